// File: rtl/alu_pkg.sv
// Shared definitions for the UART-fronted ALU: opcode values and the
// sequencer state encoding.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_GET_OP,
        ST_EXEC,
        ST_SEND_RES,
        ST_WAIT_RES,
        ST_SEND_CY,
        ST_WAIT_CY
    } ctrl_state_t;

    // Busy covers everything from the captured opcode until the last byte is done.
    function automatic logic state_is_busy(input ctrl_state_t s);
        return (s == ST_EXEC) || (s == ST_SEND_RES) || (s == ST_WAIT_RES) ||
               (s == ST_SEND_CY) || (s == ST_WAIT_CY);
    endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Inter-byte watchdog: counts enabled cycles and flags the cycle in which
// the count sits at TIMEOUT-1.
module frame_watchdog #(
    parameter int TIMEOUT = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Sequencer between the UART rx/tx pair and a combinational ALU: gathers
// A, B and opcode bytes, then returns the result (and optionally carry).
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int MAXTAM     = 8,
    parameter int SEND_CARRY = 1,
    parameter int TIMEOUT    = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [MAXTAM-1:0] i_rx_data,
    input  logic              i_rx_done,
    input  logic [MAXTAM-1:0] i_alu_result,
    input  logic              i_alu_carry,
    input  logic              i_tx_done,
    output logic [MAXTAM-1:0] o_data_a,
    output logic [MAXTAM-1:0] o_data_b,
    output logic [MAXTAM-3:0] o_op,
    output logic [MAXTAM-1:0] o_tx_data,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_timeout,
    output logic              o_drop
);

    ctrl_state_t       r_state;
    logic [MAXTAM-1:0] r_data_a;
    logic [MAXTAM-1:0] r_data_b;
    logic [MAXTAM-3:0] r_op;
    logic [MAXTAM-1:0] r_tx_data;
    logic              r_tx_start;
    logic              r_timeout;
    logic              r_carry;

    logic w_busy;
    logic w_wd_en;
    logic w_wd_clear;
    logic w_expire;

    assign w_busy     = state_is_busy(r_state);
    assign w_wd_en    = (r_state == ST_GET_B) || (r_state == ST_GET_OP);
    // Holding the counter clear outside the collect states gives the clear-on-entry.
    assign w_wd_clear = i_rx_done || !w_wd_en;

    frame_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= ST_GET_A;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_op       <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            r_carry    <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_GET_A: if (i_rx_done) begin
                    r_data_a <= i_rx_data;
                    r_state  <= ST_GET_B;
                end
                ST_GET_B: if (i_rx_done) begin
                    r_data_b <= i_rx_data;
                    r_state  <= ST_GET_OP;
                end else if (w_expire) begin
                    r_timeout <= 1'b1;
                    r_state   <= ST_GET_A;
                end
                ST_GET_OP: if (i_rx_done) begin
                    r_op    <= i_rx_data[MAXTAM-3:0];
                    r_state <= ST_EXEC;
                end else if (w_expire) begin
                    r_timeout <= 1'b1;
                    r_state   <= ST_GET_A;
                end
                // Start is raised on the way into SEND_* so it is high during that state.
                ST_EXEC: begin
                    r_tx_data  <= i_alu_result;
                    r_carry    <= i_alu_carry;
                    r_tx_start <= 1'b1;
                    r_state    <= ST_SEND_RES;
                end
                ST_SEND_RES: r_state <= ST_WAIT_RES;
                ST_WAIT_RES: if (i_tx_done) begin
                    if (SEND_CARRY != 0) begin
                        r_tx_data  <= {{(MAXTAM-1){1'b0}}, r_carry};
                        r_tx_start <= 1'b1;
                        r_state    <= ST_SEND_CY;
                    end else begin
                        r_state <= ST_GET_A;
                    end
                end
                ST_SEND_CY: r_state <= ST_WAIT_CY;
                ST_WAIT_CY: if (i_tx_done) r_state <= ST_GET_A;
                default: r_state <= ST_GET_A;
            endcase
        end
    end

    assign o_data_a   = r_data_a;
    assign o_data_b   = r_data_b;
    assign o_op       = r_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_timeout  = r_timeout;
    assign o_busy     = w_busy;
    assign o_drop     = i_rx_done && w_busy;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Bench for alu_uart_ctrl: directed and random frames against a byte-level
// reference model, plus a second instance built without the carry byte.
module tb_alu_uart_ctrl;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_r;
    logic       alu_c;
    logic [7:0] data_a, data_b, tx_data;
    logic [5:0] op;
    logic       tx_start, busy, timeout, drop;

    logic [7:0] n_rx_data = '0;
    logic       n_rx_done = 1'b0;
    logic       n_tx_done = 1'b0;
    logic [7:0] n_alu_r;
    logic       n_alu_c;
    logic [7:0] n_data_a, n_data_b, n_tx_data;
    logic [5:0] n_op;
    logic       n_tx_start, n_busy, n_timeout, n_drop;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int timeout_cnt = 0;
    int n_start_cnt = 0;
    logic [7:0] exp_q[$];

    // Reference ALU: {carry, result}; carry is carry-out for ADD, borrow for SUB.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] o);
        int s;
        case (o)
            6'b100000: begin s = int'(a) + int'(b); return {s > 255, 8'(s)}; end
            6'b100010: begin s = int'(a) - int'(b); return {s < 0, 8'(s)}; end
            6'b100100: return {1'b0, a & b};
            6'b100101: return {1'b0, a | b};
            6'b100110: return {1'b0, a ^ b};
            6'b100111: return {1'b0, ~(a | b)};
            6'b000011: return {1'b0, 8'($signed(a) >>> b)};
            6'b000010: return {1'b0, a >> b};
            default:   return 9'd0;
        endcase
    endfunction

    assign {alu_c, alu_r}     = alu_ref(data_a, data_b, op);
    assign {n_alu_c, n_alu_r} = alu_ref(n_data_a, n_data_b, n_op);

    alu_uart_ctrl #(.MAXTAM(8), .SEND_CARRY(1), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(alu_r), .i_alu_carry(alu_c), .i_tx_done(tx_done),
        .o_data_a(data_a), .o_data_b(data_b), .o_op(op), .o_tx_data(tx_data),
        .o_tx_start(tx_start), .o_busy(busy), .o_timeout(timeout), .o_drop(drop)
    );

    alu_uart_ctrl #(.MAXTAM(8), .SEND_CARRY(0), .TIMEOUT(TO)) dut_nc (
        .i_clk(clk), .i_reset(rst_n), .i_rx_data(n_rx_data), .i_rx_done(n_rx_done),
        .i_alu_result(n_alu_r), .i_alu_carry(n_alu_c), .i_tx_done(n_tx_done),
        .o_data_a(n_data_a), .o_data_b(n_data_b), .o_op(n_op), .o_tx_data(n_tx_data),
        .o_tx_start(n_tx_start), .o_busy(n_busy), .o_timeout(n_timeout), .o_drop(n_drop)
    );

    // Clock and run-time bound.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running required=finished");
        $fatal(1, "bench time limit");
    end

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_start)   start_cnt++;
        if (timeout)    timeout_cnt++;
        if (n_tx_start) n_start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic wait_start();
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_start) begin got = 1; break; end
        end
        chk("tx_start_seen", 32'(got), 32'd1);
    endtask

    task automatic pulse_tx_done(input bit with_rx);
        repeat (1 + $urandom_range(0, 3)) begin @(posedge clk); #1; end
        tx_done = 1'b1;
        if (with_rx) begin
            rx_data = 8'h5A;
            rx_done = 1'b1;
            @(negedge clk);
            chk("drop_with_tx_done", 32'(drop), 32'd1);
        end
        @(posedge clk); #1;
        tx_done = 1'b0;
        rx_done = 1'b0;
    endtask

    // mode 0: plain, 1: stray rx byte in WAIT_RES, 2: stray rx together with tx_done.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ob,
                             input int gap, input int mode);
        logic [8:0] r;
        logic [7:0] e;
        int ns, nb, idx;
        ns = start_cnt;
        r  = alu_ref(a, b, ob[5:0]);
        exp_q.push_back(r[7:0]);
        exp_q.push_back({7'd0, r[8]});
        nb = exp_q.size();
        send_byte(a);
        idle(gap < 0 ? $urandom_range(0, 3) : gap);
        send_byte(b);
        idle(gap < 0 ? $urandom_range(0, 3) : gap);
        send_byte(ob);
        @(negedge clk);
        chk("latency_cycle1_start", 32'(tx_start), 32'd0);
        chk("busy_in_exec", 32'(busy), 32'd1);
        chk("data_a", 32'(data_a), 32'(a));
        chk("data_b", 32'(data_b), 32'(b));
        chk("op", 32'(op), 32'(ob[5:0]));
        @(negedge clk);
        chk("latency_cycle2_start", 32'(tx_start), 32'd1);
        idx = 0;
        while (exp_q.size() > 0) begin
            if (idx != 0) wait_start();
            e = exp_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e));
            if (mode == 1 && idx == 0) begin
                @(posedge clk); #1;
                rx_data = 8'hAA;
                rx_done = 1'b1;
                @(negedge clk);
                chk("drop_in_wait_res", 32'(drop), 32'd1);
                @(posedge clk); #1;
                rx_done = 1'b0;
                @(negedge clk);
                chk("drop_one_cycle", 32'(drop), 32'd0);
                chk("data_a_after_drop", 32'(data_a), 32'(a));
                chk("tx_data_held", 32'(tx_data), 32'(e));
            end
            pulse_tx_done(mode == 2 && idx == 0);
            idx++;
        end
        @(negedge clk);
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("start_count", 32'(start_cnt - ns), 32'(nb));
        chk("data_a_kept", 32'(data_a), 32'(a));
    endtask

    initial begin
        logic [5:0] ops [9];
        int ns, nt;
        ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                6'b000011, 6'b000010, 6'b100111, 6'b111111};

        // Reset values
        idle(3);
        @(negedge clk);
        chk("rst_data_a", 32'(data_a), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Directed frames from the plan
        run_frame(8'h05, 8'h03, 8'h20, -1, 0);
        run_frame(8'hFF, 8'h01, 8'h20, -1, 0);
        run_frame(8'h03, 8'h05, 8'h22, -1, 0);

        // Watchdog expiry between bytes
        ns = start_cnt; nt = timeout_cnt;
        send_byte(8'h0F);
        send_byte(8'h33);
        idle(TO + 5);
        @(negedge clk);
        chk("timeout_pulses", 32'(timeout_cnt - nt), 32'd1);
        chk("timeout_no_start", 32'(start_cnt - ns), 32'd0);
        chk("timeout_keeps_a", 32'(data_a), 32'h0F);
        chk("timeout_keeps_b", 32'(data_b), 32'h33);
        chk("timeout_not_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        run_frame(8'hF0, 8'h0F, 8'h25, -1, 0);

        // Byte landing exactly on the expiry cycle is accepted
        nt = timeout_cnt;
        run_frame(8'h11, 8'h22, 8'h26, TO - 1, 0);
        chk("expiry_rx_wins", 32'(timeout_cnt - nt), 32'd0);

        // Stray bytes while busy
        run_frame(8'h40, 8'h02, 8'h02, -1, 1);
        run_frame(8'h9C, 8'h37, 8'h24, -1, 2);

        // Reset in WAIT_CY
        send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
        wait_start();
        pulse_tx_done(0);
        wait_start();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_data_a", 32'(data_a), 32'd0);
        chk("midrst_data_b", 32'(data_b), 32'd0);
        chk("midrst_op", 32'(op), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_tx_start", 32'(tx_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_timeout", 32'(timeout), 32'd0);
        ns = start_cnt;
        pulse_tx_done(0);
        idle(5);
        chk("midrst_no_start", 32'(start_cnt - ns), 32'd0);
        run_frame(8'h21, 8'h12, 8'h20, -1, 0);

        // Random frames, including an undefined opcode
        for (int i = 0; i < 20; i++) begin
            run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      {2'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]}, -1, 0);
        end

        // Instance without carry byte: SRA 0x80 by 2
        n_rx_data = 8'h80; n_rx_done = 1'b1; @(posedge clk); #1;
        n_rx_data = 8'h02; @(posedge clk); #1;
        n_rx_data = 8'h03; @(posedge clk); #1;
        n_rx_done = 1'b0;
        idle(1);
        @(negedge clk);
        chk("nc_start", 32'(n_tx_start), 32'd1);
        chk("nc_tx_data", 32'(n_tx_data), 32'hE0);
        @(posedge clk); #1;
        n_tx_done = 1'b1;
        @(posedge clk); #1;
        n_tx_done = 1'b0;
        idle(10);
        chk("nc_single_byte", 32'(n_start_cnt), 32'd1);
        chk("nc_not_busy", 32'(n_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
- Sequencer between the UART receiver/transmitter pair and the combinational ALU.
- Collects three received bytes (operand A, operand B, opcode), holds them as registered ALU inputs, and captures the ALU result and carry.
- Returns the result, and optionally a carry byte, through the UART transmitter using a start/done handshake.
- Includes an inter-byte watchdog, so a lost byte cannot leave a frame half-collected.

Parameters:
MAXTAM, 8, data width of operands, result and UART bytes (opcode width is MAXTAM-2).
SEND_CARRY, 1, 1 = send carry byte {MAXTAM-1 zeros, carry} after result byte; 0 = result byte only.
TIMEOUT, 100000, clock cycles allowed between consecutive received bytes of one frame; must be ≥2.

Ports:
i_clk  input  1  system clock, all logic on rising edge.
i_reset  input  1  synchronous, active-low reset.
i_rx_data  input  MAXTAM  byte from UART receiver, valid when i_rx_done=1.
i_rx_done  input  1  one-cycle pulse: new received byte.
i_alu_result  input  MAXTAM  ALU result.
i_alu_carry  input  1  ALU carry.
i_tx_done  input  1  one-cycle pulse: transmitter finished current byte.
o_data_a  output  MAXTAM  registered operand A to ALU.
o_data_b  output  MAXTAM  registered operand B to ALU.
o_op  output  MAXTAM-2  registered opcode to ALU (low MAXTAM-2 bits of received byte).
o_tx_data  output  MAXTAM  byte to transmit, stable from o_tx_start until i_tx_done.
o_tx_start  output  1  one-cycle pulse: start transmission.
o_busy  output  1  high from opcode capture until last byte done.
o_timeout  output  1  one-cycle pulse: frame aborted by watchdog.
o_drop  output  1  one-cycle pulse: received byte discarded (arrived while busy).

Behaviour:
- Reset (i_reset=0 at clock edge) forces state GET_A, all outputs and internal registers to 0, and watchdog cleared. It takes effect in any state, including mid-transmission.
- States and transitions:
  - GET_A: on i_rx_done, A<=i_rx_data, go to GET_B.
  - GET_B: on i_rx_done, B<=i_rx_data, go to GET_OP.
  - GET_OP: on i_rx_done, op<=i_rx_data[MAXTAM-3:0], go to EXEC.
  - EXEC (1 cycle): ALU inputs are already stable. Capture result and carry into internal registers, go to SEND_RES.
  - SEND_RES (1 cycle): o_tx_data=result, o_tx_start=1, go to WAIT_RES.
  - WAIT_RES: on i_tx_done, go to SEND_CY if SEND_CARRY=1, else GET_A.
  - SEND_CY (1 cycle): o_tx_data={0..,carry}, o_tx_start=1, go to WAIT_CY.
  - WAIT_CY: on i_tx_done, go to GET_A.
- Latency: first o_tx_start is asserted 2 cycles after the i_rx_done of the opcode byte.
- o_data_a, o_data_b and o_op keep their last values until overwritten. They are not cleared at the end of a frame.
- Opcodes are not validated. Undefined opcodes yield ALU result 0, which is transmitted normally.
- Watchdog:
  - Counter runs only in GET_B and GET_OP. It clears on every i_rx_done and on entry to those states.
  - When the counter reaches TIMEOUT-1 without i_rx_done: o_timeout pulses, state returns to GET_A, and partial operands are kept but the frame is discarded.
  - i_rx_done in the same cycle as expiry wins: the byte is accepted and there is no timeout.
- o_busy=1 in EXEC, SEND_RES, WAIT_RES, SEND_CY and WAIT_CY.
- i_rx_done while o_busy=1: byte ignored, o_drop pulses the same cycle, registers unchanged.
- i_tx_done outside WAIT_RES/WAIT_CY is ignored.
- i_rx_done and i_tx_done in the same cycle in WAIT_* states: the transition proceeds, the rx byte is dropped, and o_drop pulses.
- o_tx_start never asserts twice without an intervening i_tx_done.

Decomposition:
- Shared package alu_pkg: opcode localparams (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111) and the state encoding for alu_uart_ctrl.
- One sub-module, frame_watchdog: a counter with clear/enable inputs and an expire pulse output, parameterised by TIMEOUT.

Test Plan:
- Rx 0x05, 0x03, 0x20 with the ALU connected -> o_data_a=0x05, o_data_b=0x03, o_op=0x20; o_tx_start 2 cycles after the 3rd rx_done with tx_data 0x08; after tx_done, second start with 0x00; then back to GET_A.
- Rx 0xFF, 0x01, 0x20 -> tx bytes 0x00 then 0x01. Rx 0x03, 0x05, 0x22 -> 0xFE then 0x01.
- Rx 0x0F, 0x33; no byte for TIMEOUT cycles -> o_timeout one-cycle pulse, no o_tx_start. Next rx 0xF0, 0x0F, 0x25 -> tx 0xFF.
- Rx byte pulsed during WAIT_RES -> o_drop=1 for one cycle, o_data_a unchanged, frame completes normally.
- i_reset=0 for one cycle during WAIT_CY -> all outputs 0, state GET_A. A subsequent i_tx_done produces no o_tx_start; a new 3-byte frame works.
- SEND_CARRY=0, rx 0x80, 0x02, 0x03 (SRA) -> single tx byte 0xE0, then GET_A.
